// File: rtl/cla_byte_serial_seq_pkg.sv
// Shared definitions for the byte-serial CLA sequencer: FSM states,
// adder slice widths and the byte-index width helper.
package cla_byte_serial_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int ADD_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte index width; at least one bit so a degenerate size still elaborates.
  function automatic int idx_w(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/cla_byte_serial_seq_slice_mux.sv
// Byte selector feeding the 8-bit CLA: picks byte i_idx of the latched
// operands while enabled and drives zero otherwise so the adder stays quiet.
module cla_slice_mux
  import cla_byte_serial_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES,
  localparam int IDX_W  = idx_w(NBYTES)
) (
  input  logic              i_en,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [W-1:0]      i_a,
  input  logic [W-1:0]      i_b,
  output logic [BYTE_W-1:0] o_a,
  output logic [BYTE_W-1:0] o_b
);

  // Gated byte select of both operands.
  always_comb begin
    o_a = '0;
    o_b = '0;
    if (i_en) begin
      o_a = i_a[BYTE_W*i_idx +: BYTE_W];
      o_b = i_b[BYTE_W*i_idx +: BYTE_W];
    end
  end

endmodule

// File: rtl/cla_byte_serial_seq.sv
// Byte-serial sequencer around an external combinational 8-bit CLA.
// Operands are accepted over valid/ready, fed one byte per cycle with the
// carry chained between bytes, and the wide sum is offered over valid/ready.
// Optional macro CLA_SER_OVF_EN adds out_ovf (two's-complement overflow).
module cla_byte_serial_seq
  import cla_byte_serial_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES,
  localparam int IDX_W  = idx_w(NBYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_cin,
  output logic [BYTE_W-1:0] add_a,
  output logic [BYTE_W-1:0] add_b,
  output logic              add_cin,
  input  logic [ADD_W-1:0]  add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic              out_cout,
  output logic              busy
`ifdef CLA_SER_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             w_run;
  logic             w_done;
  logic             w_last;

  assign w_run  = (r_state == ST_RUN);
  assign w_done = (r_state == ST_DONE);
  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  cla_slice_mux #(.NBYTES(NBYTES)) u_slice_mux (
    .i_en  (w_run),
    .i_idx (r_idx),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_a   (add_a),
    .o_b   (add_b)
  );

  assign add_cin = w_run & r_carry;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, per-byte sum capture and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[BYTE_W*r_idx +: BYTE_W] <= add_sum[BYTE_W-1:0];
          r_carry                       <= add_sum[BYTE_W];
          r_idx                         <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result is only exposed in DONE so a partial sum never leaks downstream.
  assign out_sum  = w_done ? r_sum : '0;
  assign out_cout = w_done & r_carry;

`ifdef CLA_SER_OVF_EN
  logic w_c_into_msb;
  assign w_c_into_msb = r_a[W-1] ^ r_b[W-1] ^ r_sum[W-1];
  assign out_ovf      = w_done & (w_c_into_msb ^ r_carry);
`endif

endmodule
